// File: rtl/rlbp_stream_engine.sv
// Wishbone-mapped LBP engine: assembles 3x3 windows, computes plain or rotation-invariant
// 8-bit codes, buffers them in a FIFO and drains them by register reads or a serial port.
module rlbp_stream_engine #(
    parameter int         PIX_W      = 8,
    parameter int         FIFO_DEPTH = 8,
    parameter int         CLK_DIV    = 4,
    parameter logic [3:0] BASE_NIB   = 4'h3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ser_data_o,
    output logic        ser_valid_o,
    output logic        ser_frame_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_ROT, S_PUSH} state_t;

    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_en, r_ri, r_ser_en, r_irq_en;
    logic [PIX_W-1:0]  r_thr;
    logic              r_ovf, r_drop;
    logic [PIX_W-1:0]  r_pix [0:8];
    logic [3:0]        r_idx;
    state_t            r_state, w_state_nxt;
    logic [2:0]        r_rot;
    logic              r_ri_run;
    logic [7:0]        r_code, r_min;
    logic [7:0]        r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]     r_wp, r_rp;
    logic [AW:0]       r_cnt;
    logic              r_ser_act, r_ser_frame;
    logic [7:0]        r_ser_sh;
    logic [2:0]        r_ser_bit;
    logic [DW-1:0]     r_ser_div;

    logic              w_access, w_wr, w_rd;
    logic [2:0]        w_off;
    logic              w_empty, w_full, w_busy, w_clr, w_pix_wr, w_start;
    logic              w_res_pop, w_ser_last, w_ser_start, w_pop;
    logic              w_push, w_push_ok, w_ovf_set, w_drop_set;
    logic [7:0]        w_push_code, w_cmp, w_rot, w_min_nxt;
    logic [15:0]       w_rot16;
    logic [PIX_W:0]    w_thr_sum;
    logic [31:0]       w_ctrl, w_status, w_result, w_rdata;
    logic              w_unused;

    assign w_unused = ^{wbs_adr_i, wbs_sel_i, wbs_dat_i};

    // An ack blocks the following cycle, so a master holding stb gets exactly one side effect.
    assign w_access = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIB) & ~r_ack;
    assign w_wr     = w_access & wbs_we_i & wbs_sel_i[0];
    assign w_rd     = w_access & ~wbs_we_i;
    assign w_off    = wbs_adr_i[4:2];

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_busy     = (r_state != S_IDLE);
    assign w_clr      = w_wr & (w_off == 3'd0) & wbs_dat_i[3];
    assign w_pix_wr   = w_wr & (w_off == 3'd2) & r_en;
    assign w_start    = w_pix_wr & ~w_busy & (r_idx == 4'd8);
    assign w_drop_set = w_pix_wr & w_busy;

    assign w_res_pop   = w_rd & (w_off == 3'd3) & ~r_ser_en & ~w_empty;
    assign w_ser_last  = r_ser_act & (r_ser_div == '0) & (r_ser_bit == 3'd0);
    assign w_ser_start = r_ser_en & ~w_empty & (~r_ser_act | w_ser_last) & ~w_clr;
    assign w_pop       = w_res_pop | w_ser_start;

    assign w_push_code = r_ri_run ? r_min : r_code;
    assign w_push_ok   = w_push & (~w_full | w_pop) & ~w_clr;
    assign w_ovf_set   = w_push & w_full & ~w_pop & ~w_clr;

    assign w_thr_sum = {1'b0, r_pix[8]} + {1'b0, r_thr};
    assign w_rot16   = {r_code, r_code} >> r_rot;
    assign w_rot     = w_rot16[7:0];
    assign w_min_nxt = (w_rot < r_min) ? w_rot : r_min;

    always_comb begin
        w_cmp = '0;
        for (int k = 0; k < 8; k++) w_cmp[k] = ({1'b0, r_pix[k]} >= w_thr_sum);
    end

    always_comb begin
        w_ctrl              = '0;
        w_ctrl[0]           = r_en;
        w_ctrl[1]           = r_ri;
        w_ctrl[2]           = r_ser_en;
        w_ctrl[4]           = r_irq_en;
        w_ctrl[8 +: PIX_W]  = r_thr;
    end

    assign w_status = {16'd0, 8'(r_cnt), 3'd0, r_drop, r_ovf, w_busy, w_full, w_empty};
    assign w_result = w_res_pop ? {23'd0, 1'b1, r_mem[r_rp]} : 32'd0;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            3'd0:    w_rdata = w_ctrl;
            3'd1:    w_rdata = w_status;
            3'd3:    w_rdata = w_result;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_access;
            r_dat <= w_rd ? w_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_ri     <= 1'b0;
            r_ser_en <= 1'b0;
            r_irq_en <= 1'b0;
            r_thr    <= '0;
            r_ovf    <= 1'b0;
            r_drop   <= 1'b0;
            r_idx    <= '0;
            for (int i = 0; i < 9; i++) r_pix[i] <= '0;
        end else begin
            if (w_wr && w_off == 3'd0) begin
                r_en     <= wbs_dat_i[0];
                r_ri     <= wbs_dat_i[1];
                r_ser_en <= wbs_dat_i[2];
                r_irq_en <= wbs_dat_i[4];
                r_thr    <= wbs_dat_i[8 +: PIX_W];
            end
            r_ovf  <= w_ovf_set  | (r_ovf  & ~(w_wr && w_off == 3'd1 && wbs_dat_i[3]));
            r_drop <= w_drop_set | (r_drop & ~(w_wr && w_off == 3'd1 && wbs_dat_i[4]));
            if (w_pix_wr && !w_busy) begin
                r_pix[r_idx] <= wbs_dat_i[PIX_W-1:0];
                r_idx        <= (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;
            end else if (w_busy && !r_en) begin
                r_idx <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_CMP;
            S_CMP:   w_state_nxt = r_ri ? S_ROT : S_PUSH;
            S_ROT:   if (r_rot == 3'd7) w_state_nxt = S_PUSH;
            S_PUSH: begin
                w_push      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Disabling mid-compute abandons the window without pushing.
        if (r_state != S_IDLE && !r_en) begin
            w_state_nxt = S_IDLE;
            w_push      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code   <= '0;
            r_min    <= '0;
            r_rot    <= '0;
            r_ri_run <= 1'b0;
        end else begin
            case (r_state)
                S_CMP: begin
                    r_code   <= w_cmp;
                    r_min    <= 8'hFF;
                    r_rot    <= '0;
                    r_ri_run <= r_ri;
                end
                S_ROT: begin
                    r_min <= w_min_nxt;
                    r_rot <= r_rot + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wp] <= w_push_code;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_ser_act   <= 1'b0;
            r_ser_frame <= 1'b0;
            r_ser_sh    <= '0;
            r_ser_bit   <= '0;
            r_ser_div   <= '0;
        end else begin
            r_ser_frame <= 1'b0;
            if (w_ser_start) begin
                r_ser_act   <= 1'b1;
                r_ser_frame <= 1'b1;
                r_ser_sh    <= r_mem[r_rp];
                r_ser_bit   <= 3'd7;
                r_ser_div   <= DW'(CLK_DIV - 1);
            end else if (r_ser_act) begin
                if (r_ser_div != '0) begin
                    r_ser_div <= r_ser_div - 1'b1;
                end else if (r_ser_bit == 3'd0) begin
                    r_ser_act <= 1'b0;
                    r_ser_sh  <= '0;
                end else begin
                    r_ser_bit <= r_ser_bit - 3'd1;
                    r_ser_sh  <= {r_ser_sh[6:0], 1'b0};
                    r_ser_div <= DW'(CLK_DIV - 1);
                end
            end
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign ser_data_o  = r_ser_act & r_ser_sh[7];
    assign ser_valid_o = r_ser_act;
    assign ser_frame_o = r_ser_frame;
    assign irq_o       = r_irq_en & ~w_empty;

endmodule

// File: tb/tb_rlbp_stream_engine.sv
// Directed plus randomized bench for rlbp_stream_engine; expected codes come from a
// window-level LBP model and a queue standing in for the code FIFO.
module tb_rlbp_stream_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        ser_data, ser_valid, ser_frame, irq;

    int          errors = 0;
    int          checks = 0;
    int          win_n [8];
    int          win_c;
    logic [7:0]  q [$];
    logic [31:0] rd;
    logic [7:0]  exp_code, codes [2];
    logic [31:0] ctrl;
    int          acks, wait_n;
    bit          ri;

    rlbp_stream_engine dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .ser_data_o(ser_data), .ser_valid_o(ser_valid), .ser_frame_o(ser_frame), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_code(input int thr, input bit rim);
        int code, best, r8;
        code = 0;
        for (int k = 0; k < 8; k++) if (win_n[k] >= win_c + thr) code |= (1 << k);
        if (!rim) return code[7:0];
        best = 255;
        for (int r = 0; r < 8; r++) begin
            r8 = ((code >> r) | (code << (8 - r))) & 255;
            if (r8 < best) best = r8;
        end
        return best[7:0];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb(input logic w, input logic [2:0] off, input logic [31:0] d,
                      output logic [31:0] r);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; wdat = d;
        adr = {4'h3, 23'd0, off, 2'b00};
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 8);
        chk("wb_ack", {31'd0, ack}, 32'd1);
        r = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        wb(1'b1, off, d, dummy);
    endtask

    task automatic rdr(input logic [2:0] off, output logic [31:0] r);
        wb(1'b0, off, 32'd0, r);
    endtask

    task automatic rand_window();
        for (int k = 0; k < 8; k++) win_n[k] = $urandom_range(0, 255);
        win_c = $urandom_range(0, 255);
    endtask

    task automatic send_window();
        for (int k = 0; k < 8; k++) wr(3'd2, 32'(win_n[k]));
        wr(3'd2, 32'(win_c));
    endtask

    task automatic fixed_window();
        for (int k = 0; k < 8; k++) win_n[k] = 10 * (k + 1);
        win_c = 45;
    endtask

    task automatic wait_frame();
        wait_n = 0;
        while (!ser_frame && wait_n < 80) begin
            step(1);
            wait_n++;
        end
        chk("frame_seen", {31'd0, ser_frame}, 32'd1);
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_ser", {29'd0, ser_data, ser_valid, ser_frame}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        rst = 1'b0;
        step(1);
        rdr(3'd0, rd); chk("rst_ctrl", rd, 0);
        rdr(3'd1, rd); chk("rst_status", rd, 32'h1);
        wr(3'd6, 32'hFFFF_FFFF);
        rdr(3'd6, rd); chk("unmapped_read", rd, 0);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h4000_0004;
        acks = 0;
        repeat (4) begin
            step(1);
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("other_base_no_ack", 32'(acks), 0);

        // Plain code and push latency seen through irq
        wr(3'd0, 32'h11);
        fixed_window();
        send_window();
        chk("plain_irq_t1", {31'd0, irq}, 0);
        step(1); chk("plain_irq_t2", {31'd0, irq}, 0);
        step(1); chk("plain_irq_t3", {31'd0, irq}, 1);
        rdr(3'd3, rd); chk("plain_result", rd, 32'h1F0);
        rdr(3'd3, rd); chk("empty_result", rd, 0);
        chk("irq_after_drain", {31'd0, irq}, 0);

        // Rotation-invariant code and its latency
        wr(3'd0, 32'h13);
        send_window();
        step(9);  chk("ri_irq_t10", {31'd0, irq}, 0);
        step(1);  chk("ri_irq_t11", {31'd0, irq}, 1);
        rdr(3'd3, rd); chk("ri_result", rd, 32'h10F);

        // Pixel write while busy is dropped and does not move the window index
        send_window();
        rdr(3'd1, rd); chk("busy_flag", rd & 32'h4, 32'h4);
        wr(3'd2, 32'd200);
        step(12);
        rdr(3'd1, rd); chk("drop_status", rd, 32'h110);
        rdr(3'd3, rd); chk("ri_after_drop", rd, 32'h10F);
        wr(3'd1, 32'h10);
        rdr(3'd1, rd); chk("drop_cleared", rd, 32'h1);

        // Threshold boundaries
        wr(3'd0, 32'h1 | (32'd20 << 8));
        send_window(); step(12);
        rdr(3'd3, rd); chk("thr20_result", rd, 32'h1C0);
        wr(3'd0, 32'h1 | (32'd255 << 8));
        send_window(); step(12);
        rdr(3'd3, rd); chk("thr255_result", rd, 32'h100);

        // Randomized windows against the model
        for (int t = 0; t < 24; t++) begin
            int thr;
            rand_window();
            thr = (t % 3 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 30);
            ri  = 1'($urandom_range(0, 1));
            wr(3'd0, 32'h1 | (32'(ri) << 1) | (32'(thr) << 8));
            send_window(); step(12);
            exp_code = model_code(thr, ri);
            rdr(3'd3, rd); chk("rand_result", rd, {23'd0, 1'b1, exp_code});
        end

        // Overflow with FIFO_DEPTH+1 windows, then drain in order
        q.delete();
        for (int t = 0; t < 9; t++) begin
            rand_window();
            ri = 1'($urandom_range(0, 1));
            wr(3'd0, 32'h1 | (32'(ri) << 1));
            send_window(); step(12);
            if (q.size() < 8) q.push_back(model_code(0, ri));
        end
        rdr(3'd1, rd); chk("full_status", rd, 32'h80A);
        wr(3'd1, 32'h08);
        rdr(3'd1, rd); chk("ovf_cleared", rd, 32'h802);
        while (q.size() > 0) begin
            exp_code = q.pop_front();
            rdr(3'd3, rd); chk("fifo_order", rd, {23'd0, 1'b1, exp_code});
        end
        rdr(3'd1, rd); chk("drained_status", rd, 32'h1);

        // fifo_clr
        for (int t = 0; t < 2; t++) begin
            rand_window(); send_window(); step(12);
        end
        rdr(3'd1, rd); chk("pre_clr_count", rd, 32'h200);
        wr(3'd0, 32'h9);
        rdr(3'd1, rd); chk("clr_status", rd, 32'h1);
        rdr(3'd0, rd); chk("clr_reads_zero", rd, 32'h1);

        // Serial output of 0xA5
        wr(3'd0, 32'h5);
        win_n[0] = 100; win_n[1] = 0; win_n[2] = 100; win_n[3] = 0;
        win_n[4] = 0;   win_n[5] = 100; win_n[6] = 0; win_n[7] = 100;
        win_c = 50;
        exp_code = model_code(0, 1'b0);
        send_window();
        wait_frame();
        for (int i = 0; i < 32; i++) begin
            chk("ser_valid", {31'd0, ser_valid}, 1);
            chk("ser_data", {31'd0, ser_data}, {31'd0, exp_code[7 - i / 4]});
            chk("ser_frame", {31'd0, ser_frame}, {31'd0, i == 0});
            step(1);
        end
        chk("ser_valid_end", {31'd0, ser_valid}, 0);
        rdr(3'd3, rd); chk("ser_en_result", rd, 0);

        // Two queued codes stream back to back
        wr(3'd0, 32'h1);
        for (int t = 0; t < 2; t++) begin
            rand_window(); send_window(); step(12);
            codes[t] = model_code(0, 1'b0);
        end
        wr(3'd0, 32'h5);
        wait_frame();
        for (int i = 0; i < 64; i++) begin
            exp_code = codes[i / 32];
            chk("b2b_valid", {31'd0, ser_valid}, 1);
            chk("b2b_data", {31'd0, ser_data}, {31'd0, exp_code[7 - (i % 32) / 4]});
            chk("b2b_frame", {31'd0, ser_frame}, {31'd0, (i % 32) == 0});
            step(1);
        end
        chk("b2b_valid_end", {31'd0, ser_valid}, 0);

        // Reset during an RI compute and a serial shift
        wr(3'd0, 32'h17);
        rand_window(); send_window();
        wait_frame();
        rand_window(); send_window();
        step(2);
        rdr(3'd1, rd); chk("busy_before_rst", rd & 32'h4, 32'h4);
        chk("shifting_before_rst", {31'd0, ser_valid}, 1);
        rst = 1'b1;
        step(1);
        chk("rst2_ack", {31'd0, ack}, 0);
        chk("rst2_dat", rdat, 0);
        chk("rst2_ser", {29'd0, ser_data, ser_valid, ser_frame}, 0);
        chk("rst2_irq", {31'd0, irq}, 0);
        rst = 1'b0;
        step(1);
        rdr(3'd1, rd); chk("rst2_status", rd, 32'h1);
        rdr(3'd0, rd); chk("rst2_ctrl", rd, 0);
        wr(3'd0, 32'h1);
        rand_window(); send_window(); step(12);
        exp_code = model_code(0, 1'b0);
        rdr(3'd3, rd); chk("rst2_idx_zero", rd, {23'd0, 1'b1, exp_code});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
